// File: rtl/channel_noise_inject_pkg.sv
// Shared widths, default LFSR constants and the channel noise rule used by
// the noisy-channel model between the convolutional encoder and Viterbi decoder.
package channel_noise_inject_pkg;

  localparam int SYM_W = 2;
  localparam int ERR_W = 8;

  localparam logic [ERR_W-1:0] DEF_SEED = 8'hA5;
  localparam logic [ERR_W-1:0] DEF_TAPS = 8'hB8;

  // The low bits of the error draw flip the symbol only when the draw falls under the threshold.
  function automatic logic [SYM_W-1:0] noise_rule(input logic [ERR_W-1:0] e,
                                                  input logic [ERR_W-1:0] level);
    logic [SYM_W-1:0] n;
    if (e < level) begin
      n = e[SYM_W-1:0];
    end else begin
      n = {SYM_W{1'b0}};
    end
    return n;
  endfunction

endpackage

// File: rtl/channel_noise_inject_if.sv
// Symbol stream, control and statistics bundle for channel_noise_inject.
// The master side feeds symbols and consumes the corrupted stream.
interface channel_noise_inject_if #(parameter int CNT_W = 16);
  import channel_noise_inject_pkg::*;

  logic [SYM_W-1:0] in_sym;
  logic             in_valid;
  logic             in_ready;
  logic [ERR_W-1:0] err_level;
  logic             seed_load;
  logic [ERR_W-1:0] seed;
  logic [SYM_W-1:0] out_sym;
  logic [SYM_W-1:0] out_noise;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] sym_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_sym, in_valid, err_level, seed_load, seed, out_ready,
    input  in_ready, out_sym, out_noise, out_valid, sym_count, err_count
  );

  modport slave (
    input  in_sym, in_valid, err_level, seed_load, seed, out_ready,
    output in_ready, out_sym, out_noise, out_valid, sym_count, err_count
  );

endinterface

// File: rtl/channel_noise_inject_error_lfsr.sv
// Galois LFSR producing one 8-bit error draw per accepted symbol.
// A zero load value falls back to SEED so the state can never lock up at zero.
module error_lfsr
  import channel_noise_inject_pkg::*;
#(
  parameter logic [ERR_W-1:0] SEED = DEF_SEED,
  parameter logic [ERR_W-1:0] TAPS = DEF_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [ERR_W-1:0] load_val,
  output logic [ERR_W-1:0] state
);

  logic [ERR_W-1:0] state_q;
  logic [ERR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == 8'h00) ? SEED : load_val;
    end else if (step) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/channel_noise_inject.sv
// Noisy channel: corrupts each accepted symbol with an LFSR-driven error pattern,
// buffers {symbol, noise} in a small FIFO and keeps saturating BER statistics.
module channel_noise_inject
  import channel_noise_inject_pkg::*;
#(
  parameter logic [ERR_W-1:0] SEED       = DEF_SEED,
  parameter logic [ERR_W-1:0] TAPS       = DEF_TAPS,
  parameter int               FIFO_DEPTH = 4,
  parameter int               CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  channel_noise_inject_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * SYM_W;

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;
  logic [CNT_W-1:0] sym_cnt_q;
  logic [CNT_W-1:0] sym_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  logic [ERR_W-1:0] lfsr_s;
  logic [SYM_W-1:0] noise_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  error_lfsr #(.SEED(SEED), .TAPS(TAPS)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (push_s),
    .load     (bus.seed_load),
    .load_val (bus.seed),
    .state    (lfsr_s)
  );

  assign full_s       = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty_s      = (count_q == '0);
  assign bus.in_ready = !full_s && !bus.seed_load;
  assign push_s       = bus.in_valid && bus.in_ready;
  assign pop_s        = !empty_s && bus.out_ready;
  assign noise_s      = noise_rule(lfsr_s, bus.err_level);

  always_comb begin
    count_d   = count_q;
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    if (push_s && (sym_cnt_q != '1)) begin
      sym_cnt_d = sym_cnt_q + CNT_W'(1);
    end else begin
      sym_cnt_d = sym_cnt_q;
    end
    if (push_s && (noise_s != 2'b00) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Entries are cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {bus.in_sym ^ noise_s, noise_s};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q   <= count_d;
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_valid = !empty_s;
  assign bus.out_sym   = mem_q[rd_ptr_q][EW-1:SYM_W];
  assign bus.out_noise = mem_q[rd_ptr_q][SYM_W-1:0];
  assign bus.sym_count = sym_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_channel_noise_inject.sv
// Directed bench for channel_noise_inject: a queue/arithmetic channel model checked
// every cycle, plus literal expectations; a CNT_W=4 twin checks counter saturation.
module tb_channel_noise_inject;
  import channel_noise_inject_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  channel_noise_inject_if #(.CNT_W(16)) bus ();
  channel_noise_inject_if #(.CNT_W(4))  bus4 ();

  channel_noise_inject #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  channel_noise_inject #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  assign bus4.in_sym    = bus.in_sym;
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.err_level = bus.err_level;
  assign bus4.seed_load = bus.seed_load;
  assign bus4.seed      = bus.seed;
  assign bus4.out_ready = bus.out_ready;

  // Channel model: entries are (corrupted_sym*4 + noise)
  int m_q[$];
  int m_lfsr;
  int m_syms;
  int m_errs;

  function automatic int lfsr_next(input int e);
    return (e % 2 == 1) ? ((e / 2) ^ 'hB8) : (e / 2);
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_lfsr = 'hA5;
      m_syms = 0;
      m_errs = 0;
    end else begin
      int  noise;
      bit  acc;
      bit  pop;
      acc = bus.in_valid && (m_q.size() < 4) && !bus.seed_load;
      pop = (m_q.size() != 0) && bus.out_ready;
      if (pop) void'(m_q.pop_front());
      if (bus.seed_load) begin
        m_lfsr = (bus.seed == 8'h00) ? 'hA5 : int'(bus.seed);
      end else if (acc) begin
        noise = (m_lfsr < int'(bus.err_level)) ? (m_lfsr % 4) : 0;
        m_q.push_back(((int'(bus.in_sym) ^ noise) * 4) + noise);
        m_lfsr = lfsr_next(m_lfsr);
        m_syms++;
        if (noise != 0) m_errs++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", bus.in_ready, ((m_q.size() < 4) && !bus.seed_load) ? 1 : 0);
      check("out_valid", bus.out_valid, (m_q.size() != 0) ? 1 : 0);
      if (m_q.size() != 0) begin
        check("out_sym", bus.out_sym, m_q[0] / 4);
        check("out_noise", bus.out_noise, m_q[0] % 4);
      end
      check("sym_count", bus.sym_count, min_i(m_syms, 65535));
      check("err_count", bus.err_count, min_i(m_errs, 65535));
      check("sym_count4", bus4.sym_count, min_i(m_syms, 15));
      check("err_count4", bus4.err_count, min_i(m_errs, 15));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    int   n;
    logic ok;
    bus.in_sym   = s;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    bus.in_sym    = 2'b00;
    bus.in_valid  = 1'b0;
    bus.err_level = 8'h00;
    bus.seed_load = 1'b0;
    bus.seed      = 8'h00;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sym", bus.out_sym, 0);
    check("rst_out_noise", bus.out_noise, 0);
    check("rst_sym_count", bus.sym_count, 0);
    check("rst_err_count", bus.err_count, 0);
    rst = 1'b0;
    tick();

    // Clean channel passes symbols unchanged
    for (int i = 0; i < 8; i++) send(2'(i));
    drain();
    check("t1_sym_count", bus.sym_count, 8);
    check("t1_err_count", bus.err_count, 0);

    // Full-threshold noise from seed A5: draws A5, EA
    pulse_reset();
    bus.out_ready = 1'b0;
    bus.err_level = 8'hFF;
    send(2'b00);
    send(2'b00);
    check("t2_first_sym", bus.out_sym, 1);
    check("t2_first_noise", bus.out_noise, 1);
    check("t2_err_count", bus.err_count, 2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t2_second_sym", bus.out_sym, 2);
    check("t2_second_noise", bus.out_noise, 2);
    drain();

    // Backpressure: four fill the FIFO, fifth waits
    bus.out_ready = 1'b0;
    bus.err_level = 8'h40;
    send(2'b01);
    send(2'b10);
    send(2'b11);
    send(2'b00);
    @(negedge clk);
    check("t3_full_in_ready", bus.in_ready, 0);
    tick();
    bus.in_sym   = 2'b10;
    bus.in_valid = 1'b1;
    repeat (2) tick();
    check("t3_held_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    send(2'b10);
    drain();
    check("t3_empty", bus.out_valid, 0);
    check("t3_sym_count", bus.sym_count, 7);

    // Zero seed load falls back to A5 and blocks that cycle
    bus.err_level = 8'hFF;
    bus.seed_load = 1'b1;
    bus.seed      = 8'h00;
    bus.in_sym    = 2'b00;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check("t4_load_in_ready", bus.in_ready, 0);
    tick();
    bus.seed_load = 1'b0;
    send(2'b00);
    check("t4_reseed_sym", bus.out_sym, 1);
    tick();
    bus.seed_load = 1'b1;
    bus.seed      = 8'h10;
    tick();
    bus.seed_load = 1'b0;
    send(2'b11);
    check("t4_zero_low_bits_sym", bus.out_sym, 3);
    check("t4_zero_low_bits_noise", bus.out_noise, 0);
    drain();

    // Saturation on the 4-bit twin
    pulse_reset();
    bus.err_level = 8'hFF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(2'(i % 4));
    drain();
    check("t5_sym_count4", bus4.sym_count, 15);
    check("t5_sym_count16", bus.sym_count, 20);

    // Reset with buffered symbols discards everything
    bus.out_ready = 1'b0;
    send(2'b01);
    send(2'b10);
    send(2'b11);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_sym_count", bus.sym_count, 0);
    check("t6_err_count", bus.err_count, 0);
    tick();
    rst = 1'b0;
    send(2'b00);
    check("t6_first_sym", bus.out_sym, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
